// File: rtl/fetch_pkg.sv
// Shared types and decode helpers for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH0 = 2'd0,
    FETCH1 = 2'd1,
    HOLD   = 2'd2
  } fetch_state_e;

  localparam int BYTE_FIELD_HI = 13;
  localparam int BYTE_FIELD_LO = 12;

  localparam logic [1:0] BYTE_TWO_WORD = 2'b10;

  // A first word whose byte field is 2'b10 is followed by an immediate/address word.
  function automatic logic is_two_word(input logic [BYTE_FIELD_HI:0] word);
    logic [1:0] byte_field;
    byte_field = 2'(word >> BYTE_FIELD_LO);
    return byte_field == BYTE_TWO_WORD;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage in front of a registered instruction ROM: drives the ROM address
// from the PC, validates returned words against the ROM's address echo and
// assembles one- or two-word instructions for a valid/ready consumer.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ADDR_W-1:0] rom_addr_echo,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_word0,
  output logic [DATA_W-1:0] ir_word1,
  output logic              ir_two_word,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              primed;
  logic              word_ok;
  logic              accept;
  logic              load_w0;
  logic              load_w1;
  logic              w0_two;

  assign rom_addr = pc;

  // The echoed word belongs to the current PC only if the PC has been stable
  // for a full ROM round trip; a stale echo after a PC change is rejected.
  assign word_ok = fetch_en && primed && (rom_addr_echo == pc);
  assign w0_two  = is_two_word(rom_data[BYTE_FIELD_HI:0]);

  // Next-state and word-acceptance decode; redirect overrides everything.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load_w0   = 1'b0;
    load_w1   = 1'b0;
    if (redirect_valid) begin
      state_nxt = FETCH0;
    end else begin
      case (state)
        FETCH0: begin
          if (word_ok) begin
            accept    = 1'b1;
            load_w0   = 1'b1;
            state_nxt = w0_two ? FETCH1 : HOLD;
          end
        end
        FETCH1: begin
          if (word_ok) begin
            accept    = 1'b1;
            load_w1   = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (ir_valid && ir_ready) state_nxt = FETCH0;
        end
        default: state_nxt = FETCH0;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH0;
    else        state <= state_nxt;
  end

  // PC advances on each accepted word; primed marks one stable cycle since the last PC change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      primed <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      primed <= 1'b0;
    end else if (accept) begin
      pc     <= pc + ADDR_W'(1);
      primed <= 1'b0;
    end else begin
      primed <= 1'b1;
    end
  end

  // Instruction register assembly and downstream handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_valid    <= 1'b0;
      ir_word0    <= '0;
      ir_word1    <= '0;
      ir_two_word <= 1'b0;
      ir_pc       <= '0;
    end else if (redirect_valid) begin
      ir_valid <= 1'b0;
    end else if (load_w0) begin
      ir_word0    <= rom_data;
      ir_pc       <= pc;
      ir_two_word <= w0_two;
      if (!w0_two) begin
        ir_word1 <= '0;
        ir_valid <= 1'b1;
      end
    end else if (load_w1) begin
      ir_word1 <= rom_data;
      ir_valid <= 1'b1;
    end else if (state == HOLD && ir_valid && ir_ready) begin
      ir_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: registered ROM model plus directed and randomized scenarios.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [15:0] rom_addr;
  logic [15:0] rom_echo;
  logic [15:0] rom_q;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_word0;
  logic [15:0] ir_word1;
  logic        ir_two_word;
  logic [15:0] ir_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  logic [15:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .rom_addr      (rom_addr),
    .rom_addr_echo (rom_echo),
    .rom_data      (rom_q),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .ir_word0      (ir_word0),
    .ir_word1      (ir_word1),
    .ir_two_word   (ir_two_word),
    .ir_pc         (ir_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  // Registered ROM: samples the address at one edge, presents data and echo after it.
  always @(posedge clk) begin
    rom_echo <= rom_addr;
    rom_q    <= mem[rom_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic two_of(input logic [15:0] w);
    return w[13:12] == 2'b10;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [15:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (ir_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_addr(input logic [15:0] a, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (rom_addr == a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    mem[0] = 16'b0001101101011100;
    mem[3] = 16'b1010110111001100;
    mem[4] = 16'b1000010001001001;
    mem[8] = 16'b0001010010000110;
    rst_n = 1'b0; fetch_en = 1'b1; ir_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    step();
    step();
    @(negedge clk);
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ir_valid); end
    checks++; if (ir_word0 !== 16'h0 || ir_word1 !== 16'h0) begin errors++; $display("FAIL reset_words got %h/%h want 0/0", ir_word0, ir_word1); end
    checks++; if (ir_two_word !== 1'b0 || ir_pc !== 16'h0) begin errors++; $display("FAIL reset_two_pc got %b/%h want 0/0", ir_two_word, ir_pc); end
    checks++; if (rom_addr !== 16'h0) begin errors++; $display("FAIL reset_pc got %h want 0000", rom_addr); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_one_word();
    bit ok;
    wait_valid(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL one_word_timeout got 0 want 1"); end
    checks++; if (ir_word0 !== 16'b0001101101011100 || ir_two_word !== 1'b0) begin errors++; $display("FAIL one_word_w0 got %h/%b want 1b5c/0", ir_word0, ir_two_word); end
    checks++; if (ir_pc !== 16'h0 || ir_word1 !== 16'h0) begin errors++; $display("FAIL one_word_pc_w1 got %h/%h want 0/0", ir_pc, ir_word1); end
    checks++; if (rom_addr !== 16'h1) begin errors++; $display("FAIL one_word_next got %h want 0001", rom_addr); end
  endtask

  task automatic test_two_word();
    bit ok;
    redirect_to(16'h0003);
    wait_valid(12, ok);
    checks++; if (!ok) begin errors++; $display("FAIL two_word_timeout got 0 want 1"); end
    checks++; if (ir_two_word !== 1'b1 || ir_pc !== 16'h3) begin errors++; $display("FAIL two_word_flag_pc got %b/%h want 1/0003", ir_two_word, ir_pc); end
    checks++; if (ir_word0 !== mem[3] || ir_word1 !== mem[4]) begin errors++; $display("FAIL two_word_words got %h/%h want %h/%h", ir_word0, ir_word1, mem[3], mem[4]); end
    checks++; if (rom_addr !== 16'h5) begin errors++; $display("FAIL two_word_next got %h want 0005", rom_addr); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [15:0] w0, w1, pc;
    mem[10] = 16'($urandom) & 16'hCFFF;
    ir_ready = 1'b0;
    redirect_to(16'd10);
    wait_valid(12, ok);
    checks++; if (!ok || ir_pc !== 16'd10) begin errors++; $display("FAIL stall_first got %0b/%h want 1/000a", ok, ir_pc); end
    w0 = ir_word0; w1 = ir_word1; pc = ir_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (!ir_valid || ir_word0 !== w0 || ir_word1 !== w1 || ir_pc !== pc || rom_addr !== 16'd11) begin
        errors++; $display("FAIL stall_hold got v%b %h %h %h a%h want v1 %h %h %h a000b", ir_valid, ir_word0, ir_word1, ir_pc, rom_addr, w0, w1, pc);
      end
    end
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    @(negedge clk);
    checks++; if (ir_valid !== 1'b0 || rom_addr !== 16'd11) begin errors++; $display("FAIL stall_release got v%b a%h want v0 a000b", ir_valid, rom_addr); end
    wait_valid(12, ok);
    checks++; if (!ok || ir_pc !== 16'd11) begin errors++; $display("FAIL stall_next got %0b/%h want 1/000b", ok, ir_pc); end
  endtask

  task automatic test_redirect_fetch1();
    bit ok;
    bit seen3;
    ir_ready = 1'b1;
    redirect_to(16'h0003);
    wait_addr(16'h0004, 12, ok);
    checks++; if (!ok || ir_valid !== 1'b0) begin errors++; $display("FAIL mid_fetch1 got %0b/v%b want 1/v0", ok, ir_valid); end
    redirect_to(16'h0008);
    seen3 = 1'b0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ir_valid) begin
        if (ir_pc == 16'h3) seen3 = 1'b1;
        else begin ok = 1'b1; break; end
      end
    end
    checks++; if (seen3) begin errors++; $display("FAIL redirect_drop got pc0003 valid want none"); end
    checks++; if (!ok || ir_pc !== 16'h8 || ir_word0 !== 16'b0001010010000110 || ir_two_word !== 1'b0) begin
      errors++; $display("FAIL redirect_target got %0b %h %h %b want 1 0008 1486 0", ok, ir_pc, ir_word0, ir_two_word);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    mem[16'hFFFF] = (16'($urandom) & 16'hCFFF) | 16'h2000;
    redirect_to(16'hFFFF);
    wait_valid(12, ok);
    checks++; if (!ok || ir_pc !== 16'hFFFF || ir_two_word !== 1'b1) begin errors++; $display("FAIL wrap_pc got %0b %h %b want 1 ffff 1", ok, ir_pc, ir_two_word); end
    checks++; if (ir_word0 !== mem[16'hFFFF] || ir_word1 !== mem[0]) begin errors++; $display("FAIL wrap_words got %h/%h want %h/%h", ir_word0, ir_word1, mem[16'hFFFF], mem[0]); end
    checks++; if (rom_addr !== 16'h0001) begin errors++; $display("FAIL wrap_next got %h want 0001", rom_addr); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    redirect_to(16'h0003);
    wait_addr(16'h0004, 12, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach got 0 want 1"); end
    rst_n = 1'b0;
    step();
    @(negedge clk);
    checks++; if (ir_valid !== 1'b0 || ir_two_word !== 1'b0 || ir_pc !== 16'h0 || ir_word0 !== 16'h0 || ir_word1 !== 16'h0) begin
      errors++; $display("FAIL rstmid_outputs got v%b t%b %h %h %h want all zero", ir_valid, ir_two_word, ir_pc, ir_word0, ir_word1);
    end
    checks++; if (rom_addr !== 16'h0) begin errors++; $display("FAIL rstmid_pc got %h want 0000", rom_addr); end
    step();
    rst_n = 1'b1;
    wait_valid(12, ok);
    checks++; if (!ok || ir_pc !== 16'h0 || ir_word0 !== mem[0]) begin errors++; $display("FAIL rstmid_restart got %0b %h %h want 1 0000 %h", ok, ir_pc, ir_word0, mem[0]); end
  endtask

  task automatic test_fetch_en();
    bit ok;
    logic [15:0] exp_addr;
    ir_ready = 1'b0;
    fetch_en = 1'b0;
    redirect_to(16'd20);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (rom_addr !== 16'd20 || ir_valid !== 1'b0) begin errors++; $display("FAIL fen_frozen got a%h v%b want a0014 v0", rom_addr, ir_valid); end
    end
    fetch_en = 1'b1;
    wait_valid(12, ok);
    checks++; if (!ok || ir_pc !== 16'd20 || ir_word0 !== mem[20]) begin errors++; $display("FAIL fen_resume got %0b %h %h want 1 0014 %h", ok, ir_pc, ir_word0, mem[20]); end
    exp_addr = 16'd21 + (two_of(mem[20]) ? 16'd1 : 16'd0);
    fetch_en = 1'b0;
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (ir_valid !== 1'b0 || rom_addr !== exp_addr) begin errors++; $display("FAIL fen_hold_hs got v%b a%h want v0 a%h", ir_valid, rom_addr, exp_addr); end
    end
    fetch_en = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] ptr, nxt, e_w1, p_w0, p_w1, p_pc, p_addr;
    logic        e_two, synced, hold_prev, redir_prev, fen_prev, moved_prev, have_prev;
    int          hs;
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    ptr = '0; synced = 1'b0; hold_prev = 1'b0; have_prev = 1'b0;
    redir_prev = 1'b0; fen_prev = 1'b0; moved_prev = 1'b0;
    p_w0 = '0; p_w1 = '0; p_pc = '0; p_addr = '0; hs = 0;
    for (int i = 0; i < 4000; i++) begin
      fetch_en       = ($urandom % 100) < 85;
      ir_ready       = ($urandom % 100) < 60;
      redirect_valid = (i == 0) || (($urandom % 100) < 3);
      redirect_pc    = 16'($urandom);
      @(negedge clk);
      if (hold_prev) begin
        checks++;
        if (!ir_valid || ir_word0 !== p_w0 || ir_word1 !== p_w1 || ir_pc !== p_pc || rom_addr !== p_addr) begin
          errors++; $display("FAIL rnd_stall got v%b %h %h %h a%h want v1 %h %h %h a%h", ir_valid, ir_word0, ir_word1, ir_pc, rom_addr, p_w0, p_w1, p_pc, p_addr);
        end
      end
      if (have_prev && !redir_prev) begin
        checks++;
        if ((!fen_prev || moved_prev) ? (rom_addr !== p_addr) : (rom_addr !== p_addr && rom_addr !== p_addr + 16'd1)) begin
          errors++; $display("FAIL rnd_pc_step got %h want %h (fen %b moved %b)", rom_addr, p_addr, fen_prev, moved_prev);
        end
      end
      if (ir_valid && ir_ready && synced) begin
        nxt   = ptr + 16'd1;
        e_two = two_of(mem[ptr]);
        e_w1  = e_two ? mem[nxt] : 16'h0;
        checks++;
        if (ir_word0 !== mem[ptr] || ir_two_word !== e_two || ir_word1 !== e_w1 || ir_pc !== ptr) begin
          errors++; $display("FAIL rnd_instr got %h %b %h %h want %h %b %h %h", ir_word0, ir_two_word, ir_word1, ir_pc, mem[ptr], e_two, e_w1, ptr);
        end
        ptr = ptr + (e_two ? 16'd2 : 16'd1);
        hs++;
      end
      if (redirect_valid) begin
        ptr    = redirect_pc;
        synced = 1'b1;
      end
      moved_prev = redirect_valid || (have_prev && rom_addr !== p_addr);
      hold_prev  = ir_valid && !ir_ready && !redirect_valid;
      redir_prev = redirect_valid;
      fen_prev   = fetch_en;
      have_prev  = 1'b1;
      p_w0 = ir_word0; p_w1 = ir_word1; p_pc = ir_pc; p_addr = rom_addr;
      step();
    end
    redirect_valid = 1'b0;
    checks++; if (hs < 20) begin errors++; $display("FAIL rnd_progress got %0d want >=20", hs); end
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_two_word();
    test_stall();
    test_redirect_fetch1();
    test_wrap();
    test_reset_mid();
    test_fetch_en();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction ROM.
- Drives the ROM address from an internal program counter and captures the registered ROM data.
- Validates each returned word against the ROM's address echo.
- Assembles one- and two-word instructions into an instruction register, handed downstream over a valid/ready handshake.
- Accepts branch redirects from the decode/execute side.

Parameters:
ADDR_W, 16, program counter / ROM address width
DATA_W, 16, instruction word width
RESET_PC, 16'h0000, PC value loaded at reset

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
fetch_en  input  1  1 = fetching allowed; 0 = PC frozen, no words accepted
rom_addr  output  ADDR_W  address to ROM (= PC register)
rom_addr_echo  input  ADDR_W  ROM's registered copy of the address it sampled
rom_data  input  DATA_W  ROM's registered instruction word for rom_addr_echo
ir_valid  output  1  instruction register holds a complete instruction
ir_ready  input  1  downstream accepts the instruction this cycle
ir_word0  output  DATA_W  first instruction word
ir_word1  output  DATA_W  second word (immediate/address); 0 for one-word instructions
ir_two_word  output  1  instruction is two words long
ir_pc  output  ADDR_W  address of ir_word0
redirect_valid  input  1  branch/jump redirect request
redirect_pc  input  ADDR_W  redirect target

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset values:
  - PC = RESET_PC; state = FETCH0; primed = 0.
  - ir_valid = 0; ir_word0 = ir_word1 = 0; ir_two_word = 0; ir_pc = 0.
- ROM timing:
  - The ROM samples rom_addr at edge N and presents rom_data/rom_addr_echo after edge N.
  - The fetch unit samples them at edge N+1.
- Word acceptance: a word is accepted at an edge only when all of the following hold:
  - fetch_en = 1;
  - primed = 1, meaning PC was unchanged across the previous edge;
  - rom_addr_echo == PC;
  - state is FETCH0 or FETCH1.
- On every accepted word, PC increments by 1, wrapping 16'hFFFF -> 16'h0000. primed clears whenever PC changes and sets after one stable cycle.
- Throughput: at most one accepted word every 2 cycles.
- Instruction length: decoded from word0 bits [13:12] (byte field). 2'b10 means two words; 00, 01 and 11 mean one word.
- FSM:
  - FETCH0, word accepted:
    - ir_word0 <= rom_data; ir_pc <= PC.
    - One-word: ir_word1 <= 0, ir_two_word <= 0, ir_valid <= 1, go to HOLD.
    - Two-word: ir_two_word <= 1, go to FETCH1.
  - FETCH1, word accepted: ir_word1 <= rom_data, ir_valid <= 1, go to HOLD.
  - HOLD, ir_valid & ir_ready: ir_valid <= 0, go to FETCH0. PC already points to the next instruction.
  - HOLD, ir_ready = 0: all ir_* outputs held stable; PC held.
- Output stability: ir_valid never drops without a handshake, except on redirect or reset.
- Redirect (highest priority, any state):
  - PC <= redirect_pc; primed <= 0; state <= FETCH0; ir_valid <= 0 on the next cycle.
  - Any partially assembled instruction is discarded.
  - A handshake in the same cycle counts as consumed.
  - A stale echo after redirect fails the compare and is ignored.
- Two-word instruction at 16'hFFFF: the second word is fetched from 16'h0000; ir_pc = 16'hFFFF.
- fetch_en = 0: acceptance blocked, PC frozen, HOLD handshake still permitted; redirect still honoured.
- Reset asserted mid-instruction: all state returns to reset values at that edge; no partial output.

Decomposition:
- Package fetch_pkg holds:
  - state enum {FETCH0, FETCH1, HOLD};
  - BYTE_FIELD_HI = 13, BYTE_FIELD_LO = 12;
  - BYTE_TWO_WORD = 2'b10;
  - function is_two_word(word) returning 1 for a two-word first word.
- No sub-module; PC, FSM and instruction register stay in one module.

Test Plan:
- Reset then run; ROM[0] = 16'b0001101101011100, ir_ready = 1 -> ir_valid with word0 = that value, ir_two_word = 0, ir_pc = 0, ir_word1 = 0. rom_addr then reads 1.
- Redirect to 3; ROM[3] = 16'b1010110111001100, ROM[4] = 16'b1000010001001001 -> one instruction with ir_two_word = 1, word0 = ROM[3], word1 = ROM[4], ir_pc = 3. Next rom_addr = 5.
- ir_ready held 0 for 5 cycles after ir_valid -> ir_* stable and rom_addr frozen. Release -> exactly one handshake, then FETCH0 at next address.
- Redirect to 8 while in FETCH1 of the two-word instruction at 3 -> partial instruction dropped, no ir_valid for address 3. Next ir_pc = 8 with word0 = ROM[8] = 16'b0001010010000110.
- Bench ROM model, redirect to 16'hFFFF holding a byte = 10 word -> word1 taken from 16'h0000, ir_pc = 16'hFFFF, next rom_addr = 16'h0001.
- Drive rst_n = 0 during FETCH1 and fetch_en = 0 episodes -> outputs return to reset values. With fetch_en = 0 the PC does not advance and no word is accepted even when the echo matches.
